// File: rtl/mips_pkg.sv
// mips_pkg: forwarding-select codes, pipeline slot type and writer-match helper
package mips_pkg;
  localparam int RIDX_W = 5;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;
  localparam logic [1:0] FWD_RET = 2'b11;
  localparam logic [RIDX_W-1:0] REG_ZERO = '0;
  typedef struct packed {
    logic              valid;
    logic              we;
    logic              load;
    logic [RIDX_W-1:0] dst;
  } slot_t;
  // A slot writes r when it is a live register writer of r; the load flag is irrelevant here
  // and $0 never matches.
  function automatic logic slot_writes(slot_t s, logic [RIDX_W-1:0] r);
    slot_t w;
    w = '{valid: 1'b1, we: 1'b1, load: s.load, dst: r};
    return (s == w) && (r != REG_ZERO);
  endfunction
endpackage

// File: rtl/fwd_ctrl_if.sv
// fwd_ctrl_if: ID-stage request and EX operand-mux select bundle between core and fwd_ctrl
//   master: core side (drives hold/flush/ID fields, receives selects/stall/bubble)
//   slave : fwd_ctrl side
interface fwd_ctrl_if #(
  parameter int REG_W = 5
);
  logic             i_hold;
  logic             i_flush;
  logic             i_id_valid;
  logic [REG_W-1:0] i_id_rs;
  logic [REG_W-1:0] i_id_rt;
  logic [REG_W-1:0] i_id_dst;
  logic             i_id_we;
  logic             i_id_load;
  logic [1:0]       o_fwd_a;
  logic [1:0]       o_fwd_b;
  logic             o_stall;
  logic             o_ex_bubble;
  modport master (
    output i_hold, i_flush, i_id_valid, i_id_rs, i_id_rt, i_id_dst, i_id_we, i_id_load,
    input  o_fwd_a, o_fwd_b, o_stall, o_ex_bubble
  );
  modport slave (
    input  i_hold, i_flush, i_id_valid, i_id_rs, i_id_rt, i_id_dst, i_id_we, i_id_load,
    output o_fwd_a, o_fwd_b, o_stall, o_ex_bubble
  );
endinterface

// File: rtl/fwd_sel.sv
// fwd_sel: newest-first forwarding priority for one source operand
//   i_r            operand register index
//   i_ex/mem/wb    pipeline slots before the edge
//   o_sel          operand Mux4 select for the instruction entering EX
//   o_ld_hit       EX slot is a load writing i_r (load-use hazard term)
module fwd_sel
  import mips_pkg::*;
#(
  parameter int REG_W     = RIDX_W,
  parameter bit RF_BYPASS = 1'b0
) (
  input  logic [REG_W-1:0] i_r,
  input  slot_t            i_ex,
  input  slot_t            i_mem,
  input  slot_t            i_wb,
  output logic [1:0]       o_sel,
  output logic             o_ld_hit
);
  logic w_ex, w_mem, w_wb;
  always_comb begin
    w_ex     = slot_writes(i_ex, i_r);
    w_mem    = slot_writes(i_mem, i_r);
    w_wb     = slot_writes(i_wb, i_r);
    // The current EX writer will sit in EX/MEM once the consumer reaches EX, and so on down.
    o_sel    = w_ex ? FWD_MEM : w_mem ? FWD_WB : (w_wb && !RF_BYPASS) ? FWD_RET : FWD_RF;
    o_ld_hit = w_ex && i_ex.load;
  end
endmodule

// File: rtl/fwd_ctrl.sv
// fwd_ctrl: 5-stage MIPS hazard controller driving the EX operand-mux selects
//   i_clk, i_rst   clock (rising edge), asynchronous active-high reset
//   bus.i_*        hold, flush and ID instruction fields from the core
//   bus.o_fwd_a/b  registered operand-A/B selects for the instruction in EX
//   bus.o_stall    combinational load-use stall for PC and IF/ID
//   bus.o_ex_bubble registered flag: EX holds a bubble
module fwd_ctrl
  import mips_pkg::*;
#(
  parameter int REG_W     = RIDX_W,
  parameter bit RF_BYPASS = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  fwd_ctrl_if.slave   bus
);
  slot_t      r_ex, r_mem, r_wb;
  logic [1:0] r_fwd_a, r_fwd_b, w_sel_a, w_sel_b;
  logic       r_bubble, w_ld_a, w_ld_b, w_hz, w_stall, w_enter;
  fwd_sel #(.REG_W(REG_W), .RF_BYPASS(RF_BYPASS)) u_sel_a (
    .i_r(bus.i_id_rs), .i_ex(r_ex), .i_mem(r_mem), .i_wb(r_wb), .o_sel(w_sel_a), .o_ld_hit(w_ld_a)
  );
  fwd_sel #(.REG_W(REG_W), .RF_BYPASS(RF_BYPASS)) u_sel_b (
    .i_r(bus.i_id_rt), .i_ex(r_ex), .i_mem(r_mem), .i_wb(r_wb), .o_sel(w_sel_b), .o_ld_hit(w_ld_b)
  );
  always_comb begin
    w_hz    = bus.i_id_valid && (w_ld_a || w_ld_b);
    // Hold beats flush beats stall.
    w_stall = w_hz && !bus.i_hold && !bus.i_flush;
    w_enter = bus.i_id_valid && !w_stall && !bus.i_flush;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ex     <= '0;
      r_mem    <= '0;
      r_wb     <= '0;
      r_fwd_a  <= FWD_RF;
      r_fwd_b  <= FWD_RF;
      r_bubble <= 1'b1;
    end else if (!bus.i_hold) begin
      r_wb     <= r_mem;
      r_mem    <= r_ex;
      r_ex     <= w_enter ? slot_t'{valid: 1'b1, we: bus.i_id_we, load: bus.i_id_load, dst: bus.i_id_dst} : '0;
      r_fwd_a  <= w_enter ? w_sel_a : FWD_RF;
      r_fwd_b  <= w_enter ? w_sel_b : FWD_RF;
      r_bubble <= !w_enter;
    end
  end
  assign bus.o_fwd_a     = r_fwd_a;
  assign bus.o_fwd_b     = r_fwd_b;
  assign bus.o_stall     = w_stall;
  assign bus.o_ex_bubble = r_bubble;
endmodule

// File: tb/tb_fwd_ctrl.sv
// tb_fwd_ctrl: directed hazard scenarios checked against a pipeline-history model
module tb_fwd_ctrl;
  localparam bit RFB = 1'b0;
  typedef struct packed {
    logic       v;
    logic       we;
    logic       ld;
    logic [4:0] d;
  } ent_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  int checks = 0;
  int errors = 0;
  ent_t hist [3] = '{default: '0};
  logic [1:0] m_fa = 2'b00;
  logic [1:0] m_fb = 2'b00;
  logic m_bub = 1'b1;
  fwd_ctrl_if #(.REG_W(5)) bus ();
  fwd_ctrl #(.REG_W(5), .RF_BYPASS(RFB)) dut (.i_clk(clk), .i_rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  function automatic logic wr(ent_t e, logic [4:0] r);
    return e.v && e.we && e.d == r && r != 5'd0;
  endfunction
  function automatic logic [1:0] pick(logic [4:0] r);
    logic [1:0] s;
    s = 2'b00;
    for (int i = 2; i >= 0; i--)
      if (wr(hist[i], r)) s = (i == 0) ? 2'b01 : (i == 1) ? 2'b10 : (RFB ? 2'b00 : 2'b11);
    return s;
  endfunction
  function automatic logic m_stall();
    return bus.i_id_valid && hist[0].ld && (wr(hist[0], bus.i_id_rs) || wr(hist[0], bus.i_id_rt))
           && !bus.i_hold && !bus.i_flush;
  endfunction
  function automatic logic m_enter();
    return bus.i_id_valid && !m_stall() && !bus.i_flush;
  endfunction
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist  <= '{default: '0};
      m_fa  <= 2'b00;
      m_fb  <= 2'b00;
      m_bub <= 1'b1;
    end else if (!bus.i_hold) begin
      m_fa    <= m_enter() ? pick(bus.i_id_rs) : 2'b00;
      m_fb    <= m_enter() ? pick(bus.i_id_rt) : 2'b00;
      m_bub   <= !m_enter();
      hist[2] <= hist[1];
      hist[1] <= hist[0];
      hist[0] <= m_enter() ? ent_t'{v: 1'b1, we: bus.i_id_we, ld: bus.i_id_load, d: bus.i_id_dst} : '0;
    end
  end
  task automatic chk(string n, logic [1:0] got, logic [1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b at %0t", n, got, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (en) begin
      chk("model_stall", {1'b0, bus.o_stall}, {1'b0, m_stall()});
      chk("model_fwd_a", bus.o_fwd_a, m_fa);
      chk("model_fwd_b", bus.o_fwd_b, m_fb);
      chk("model_bubble", {1'b0, bus.o_ex_bubble}, {1'b0, m_bub});
    end
  end
  task automatic si(logic v, logic [4:0] rs, logic [4:0] rt, logic [4:0] dst, logic we, logic ld);
    bus.i_id_valid = v;
    bus.i_id_rs    = rs;
    bus.i_id_rt    = rt;
    bus.i_id_dst   = dst;
    bus.i_id_we    = we;
    bus.i_id_load  = ld;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle(int n);
    si(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    repeat (n) tick();
  endtask
  task automatic lit(string n, logic [1:0] got, logic [1:0] exp);
    chk(n, got, exp);
  endtask
  initial begin
    bus.i_hold  = 1'b0;
    bus.i_flush = 1'b0;
    si(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    #1 rst = 1'b1;
    en = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    lit("rst_bubble", {1'b0, bus.o_ex_bubble}, 2'b01);
    lit("rst_fwd_a", bus.o_fwd_a, 2'b00);
    lit("rst_fwd_b", bus.o_fwd_b, 2'b00);
    lit("rst_stall", {1'b0, bus.o_stall}, 2'b00);
    si(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0); tick();
    lit("alu1_producer_bubble", {1'b0, bus.o_ex_bubble}, 2'b00);
    si(1'b1, 5'd3, 5'd4, 5'd8, 1'b1, 1'b0); tick();
    lit("alu_dist1_a", bus.o_fwd_a, 2'b01);
    lit("alu_dist1_b", bus.o_fwd_b, 2'b00);
    idle(3);
    si(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0); tick();
    idle(1);
    si(1'b1, 5'd3, 5'd4, 5'd8, 1'b1, 1'b0); tick();
    lit("alu_dist2_a", bus.o_fwd_a, 2'b10);
    idle(3);
    si(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0); tick();
    idle(2);
    si(1'b1, 5'd3, 5'd4, 5'd8, 1'b1, 1'b0); tick();
    lit("alu_dist3_a", bus.o_fwd_a, 2'b11);
    idle(3);
    si(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1); tick();
    si(1'b1, 5'd2, 5'd5, 5'd6, 1'b1, 1'b0); #1;
    lit("lu_stall", {1'b0, bus.o_stall}, 2'b01);
    tick();
    lit("lu_bubble", {1'b0, bus.o_ex_bubble}, 2'b01);
    lit("lu_stall_clears", {1'b0, bus.o_stall}, 2'b00);
    lit("lu_bubble_fwd_b", bus.o_fwd_b, 2'b00);
    tick();
    lit("lu_enter_bubble", {1'b0, bus.o_ex_bubble}, 2'b00);
    lit("lu_fwd_b", bus.o_fwd_b, 2'b10);
    lit("lu_fwd_a", bus.o_fwd_a, 2'b00);
    idle(3);
    si(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0); tick();
    si(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0); tick();
    lit("r0_fwd_a", bus.o_fwd_a, 2'b00);
    lit("r0_fwd_b", bus.o_fwd_b, 2'b00);
    idle(3);
    si(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0); tick();
    si(1'b1, 5'd3, 5'd4, 5'd7, 1'b1, 1'b0); tick();
    si(1'b1, 5'd7, 5'd7, 5'd9, 1'b1, 1'b0); tick();
    lit("newest_fwd_a", bus.o_fwd_a, 2'b01);
    lit("newest_fwd_b", bus.o_fwd_b, 2'b01);
    idle(3);
    si(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1); tick();
    si(1'b1, 5'd9, 5'd9, 5'd6, 1'b1, 1'b0);
    bus.i_flush = 1'b1; #1;
    lit("flush_stall", {1'b0, bus.o_stall}, 2'b00);
    tick();
    bus.i_flush = 1'b0;
    lit("flush_bubble", {1'b0, bus.o_ex_bubble}, 2'b01);
    lit("flush_fwd_a", bus.o_fwd_a, 2'b00);
    lit("flush_fwd_b", bus.o_fwd_b, 2'b00);
    idle(3);
    si(1'b1, 5'd1, 5'd2, 5'd10, 1'b1, 1'b1); tick();
    lit("hold_lw_bubble", {1'b0, bus.o_ex_bubble}, 2'b00);
    si(1'b1, 5'd3, 5'd10, 5'd6, 1'b1, 1'b0); #1;
    lit("hold_pre_stall", {1'b0, bus.o_stall}, 2'b01);
    bus.i_hold = 1'b1; #1;
    lit("hold_stall", {1'b0, bus.o_stall}, 2'b00);
    for (int i = 0; i < 3; i++) begin
      tick();
      lit("hold_frozen_bubble", {1'b0, bus.o_ex_bubble}, 2'b00);
      lit("hold_frozen_fwd_b", bus.o_fwd_b, 2'b00);
      lit("hold_frozen_stall", {1'b0, bus.o_stall}, 2'b00);
    end
    bus.i_hold = 1'b0; #1;
    lit("hold_resume_stall", {1'b0, bus.o_stall}, 2'b01);
    tick();
    lit("hold_resume_bubble", {1'b0, bus.o_ex_bubble}, 2'b01);
    tick();
    lit("hold_resume_fwd_b", bus.o_fwd_b, 2'b10);
    lit("hold_resume_enter", {1'b0, bus.o_ex_bubble}, 2'b00);
    idle(3);
    si(1'b1, 5'd1, 5'd2, 5'd12, 1'b1, 1'b0); tick();
    si(1'b1, 5'd12, 5'd2, 5'd11, 1'b1, 1'b1); tick();
    lit("rst_pre_fwd_a", bus.o_fwd_a, 2'b01);
    si(1'b1, 5'd3, 5'd11, 5'd6, 1'b1, 1'b0); #1;
    lit("rst_pre_stall", {1'b0, bus.o_stall}, 2'b01);
    rst = 1'b1; #1;
    lit("async_rst_stall", {1'b0, bus.o_stall}, 2'b00);
    lit("async_rst_bubble", {1'b0, bus.o_ex_bubble}, 2'b01);
    lit("async_rst_fwd_a", bus.o_fwd_a, 2'b00);
    tick();
    rst = 1'b0;
    tick();
    lit("post_rst_enter", {1'b0, bus.o_ex_bubble}, 2'b00);
    lit("post_rst_fwd_a", bus.o_fwd_a, 2'b00);
    lit("post_rst_fwd_b", bus.o_fwd_b, 2'b00);
    idle(3);
    en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
